// File: rtl/tagger_if.sv
// Bundle of the tagger controller's game inputs and tagger/square control outputs.
// The master side produces frames, buttons and hit flags; the slave side is the controller.
interface tagger_if;
    logic       frame;
    logic       btnC;
    logic       btnU;
    logic       btnD;
    logic       btnL;
    logic       btnR;
    logic       topHit;
    logic       bottomHit;
    logic       leftHit;
    logic       rightHit;
    logic       allFrozen;
    logic       upDownLD;
    logic       leftRightLD;
    logic       cntUp;
    logic       cntDown;
    logic       cntLeft;
    logic       cntRight;
    logic       activeGreen;
    logic       syncFlash;
    logic [1:0] gameState;

    modport master (
        output frame, btnC, btnU, btnD, btnL, btnR,
        output topHit, bottomHit, leftHit, rightHit, allFrozen,
        input  upDownLD, leftRightLD, cntUp, cntDown, cntLeft, cntRight,
        input  activeGreen, syncFlash, gameState
    );

    modport slave (
        input  frame, btnC, btnU, btnD, btnL, btnR,
        input  topHit, bottomHit, leftHit, rightHit, allFrozen,
        output upDownLD, leftRightLD, cntUp, cntDown, cntLeft, cntRight,
        output activeGreen, syncFlash, gameState
    );
endinterface

// File: rtl/tagger_ctrl.sv
// Round sequencer for the tagger square: IDLE -> PLAY -> WIN/OVER -> IDLE, with a
// frame-based game timer, a flash timer, and registered load/step/visibility strobes.
module tagger_ctrl #(
    parameter int GAME_FRAMES  = 1800,
    parameter int FLASH_FRAMES = 15,
    parameter int CNT_W        = 11
) (
    input  logic     clk,
    input  logic     reset,
    tagger_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_OVER = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] GAME_LAST  = CNT_W'(GAME_FRAMES - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] game_cnt_q, game_cnt_d;
    logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
    logic             btnc_q, btnc_d;
    logic             ud_ld_q, ud_ld_d;
    logic             lr_ld_q, lr_ld_d;
    logic             cnt_up_q, cnt_up_d;
    logic             cnt_down_q, cnt_down_d;
    logic             cnt_left_q, cnt_left_d;
    logic             cnt_right_q, cnt_right_d;
    logic             active_green_q, active_green_d;
    logic             sync_flash_q, sync_flash_d;
    logic             start_edge;

    assign start_edge = bus.btnC & ~btnc_q;

    // Next-state logic and game timer.
    always_comb begin
        state_d    = state_q;
        game_cnt_d = game_cnt_q;
        btnc_d     = bus.btnC;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d    = ST_PLAY;
                    game_cnt_d = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (bus.frame) begin
                    if (bus.allFrozen) begin
                        state_d = ST_WIN;
                    end else if (game_cnt_q == GAME_LAST) begin
                        state_d = ST_OVER;
                    end else begin
                        game_cnt_d = game_cnt_q + CNT_ONE;
                    end
                end else begin
                    game_cnt_d = game_cnt_q;
                end
            end
            ST_WIN, ST_OVER: begin
                if (start_edge) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output strobes and flash timer, derived from the state being entered.
    always_comb begin
        ud_ld_d        = 1'b1;
        lr_ld_d        = 1'b1;
        cnt_up_d       = 1'b0;
        cnt_down_d     = 1'b0;
        cnt_left_d     = 1'b0;
        cnt_right_d    = 1'b0;
        active_green_d = 1'b1;
        sync_flash_d   = 1'b0;
        flash_cnt_d    = flash_cnt_q;
        case (state_d)
            ST_IDLE: flash_cnt_d = CNT_ZERO;
            ST_PLAY: begin
                ud_ld_d     = 1'b0;
                lr_ld_d     = 1'b0;
                cnt_up_d    = bus.btnU & ~bus.btnD & ~bus.topHit;
                cnt_down_d  = bus.btnD & ~bus.btnU & ~bus.bottomHit;
                cnt_left_d  = bus.btnL & ~bus.btnR & ~bus.leftHit;
                cnt_right_d = bus.btnR & ~bus.btnL & ~bus.rightHit;
            end
            ST_WIN: begin
                ud_ld_d        = 1'b0;
                lr_ld_d        = 1'b0;
                active_green_d = 1'b0;
                if (state_q != ST_WIN) begin
                    sync_flash_d = 1'b1;
                    flash_cnt_d  = CNT_ZERO;
                end else if (bus.frame) begin
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_cnt_d  = CNT_ZERO;
                        sync_flash_d = ~sync_flash_q;
                    end else begin
                        flash_cnt_d  = flash_cnt_q + CNT_ONE;
                        sync_flash_d = sync_flash_q;
                    end
                end else begin
                    sync_flash_d = sync_flash_q;
                end
            end
            ST_OVER: begin
                ud_ld_d        = 1'b0;
                lr_ld_d        = 1'b0;
                active_green_d = 1'b0;
            end
            default: flash_cnt_d = CNT_ZERO;
        endcase
    end

    // State, counters and output registers; btnc_q follows btnC even in reset so a
    // button held through reset release is not mistaken for a fresh press.
    always_ff @(posedge clk) begin
        btnc_q <= btnc_d;
        if (reset) begin
            state_q        <= ST_IDLE;
            game_cnt_q     <= CNT_ZERO;
            flash_cnt_q    <= CNT_ZERO;
            ud_ld_q        <= 1'b1;
            lr_ld_q        <= 1'b1;
            cnt_up_q       <= 1'b0;
            cnt_down_q     <= 1'b0;
            cnt_left_q     <= 1'b0;
            cnt_right_q    <= 1'b0;
            active_green_q <= 1'b1;
            sync_flash_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            game_cnt_q     <= game_cnt_d;
            flash_cnt_q    <= flash_cnt_d;
            ud_ld_q        <= ud_ld_d;
            lr_ld_q        <= lr_ld_d;
            cnt_up_q       <= cnt_up_d;
            cnt_down_q     <= cnt_down_d;
            cnt_left_q     <= cnt_left_d;
            cnt_right_q    <= cnt_right_d;
            active_green_q <= active_green_d;
            sync_flash_q   <= sync_flash_d;
        end
    end

    assign bus.gameState   = state_q;
    assign bus.upDownLD    = ud_ld_q;
    assign bus.leftRightLD = lr_ld_q;
    assign bus.cntUp       = cnt_up_q;
    assign bus.cntDown     = cnt_down_q;
    assign bus.cntLeft     = cnt_left_q;
    assign bus.cntRight    = cnt_right_q;
    assign bus.activeGreen = active_green_q;
    assign bus.syncFlash   = sync_flash_q;

endmodule
